// File: rtl/phase_sequencer.sv
// Variable-length micro-sequencer issuing one-cycle phase strobes to the multi-cycle CPU datapath.
// Optional single-step mode: define SINGLE_STEP_EN to add the step input.
module phase_sequencer #(
    parameter int unsigned MAX_OPS = 3,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             stall,
    input  logic             halt,
    input  logic [3:0]       num_of_ope,
`ifdef SINGLE_STEP_EN
    input  logic             step,
`endif
    output logic             ph_fetch,
    output logic             ph_decode,
    output logic             ph_select,
    output logic             ph_exec,
    output logic             ph_eip,
    output logic [1:0]       op_idx,
    output logic             busy,
    output logic             halted,
    output logic             err_bad_ops,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_SEL    = 3'd3,
        ST_EXEC   = 3'd4,
        ST_EIP    = 3'd5,
        ST_HALTED = 3'd6
    } state_t;

    localparam logic [3:0]       MAX_OPS_C = 4'(MAX_OPS);
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_r;
    state_t           state_s;
    logic [1:0]       op_idx_r;
    logic [1:0]       op_idx_s;
    logic [3:0]       num_r;
    logic [3:0]       num_s;
    logic             err_r;
    logic             err_s;
    logic             retire_s;
    logic [CNT_W-1:0] retired_r;
    logic             go_s;
    logic             cont_s;

    // Leaving IDLE and continuing after EIP depend on whether single-step mode is built in
`ifdef SINGLE_STEP_EN
    assign go_s   = step;
    assign cont_s = 1'b0;
`else
    assign go_s   = run;
    assign cont_s = run;
`endif

    // Next-state, micro-op index and decode latch; everything holds while stalled
    always_comb begin
        state_s  = state_r;
        op_idx_s = op_idx_r;
        num_s    = num_r;
        err_s    = 1'b0;
        retire_s = 1'b0;
        if (stall) begin
            state_s = state_r;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (go_s) begin
                        state_s = ST_FETCH;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_FETCH: begin
                    state_s = ST_DECODE;
                end
                ST_DECODE: begin
                    op_idx_s = 2'd0;
                    if (num_of_ope > MAX_OPS_C) begin
                        num_s = MAX_OPS_C;
                        err_s = 1'b1;
                    end else begin
                        num_s = num_of_ope;
                        err_s = 1'b0;
                    end
                    if (num_of_ope == 4'd0) begin
                        state_s = ST_EIP;
                    end else begin
                        state_s = ST_SEL;
                    end
                end
                ST_SEL: begin
                    state_s = ST_EXEC;
                end
                ST_EXEC: begin
                    // num_r is at least 1 here, so op_idx+1 < num_r is op_idx < num_r-1
                    if (({2'b00, op_idx_r} + 4'd1) < num_r) begin
                        op_idx_s = op_idx_r + 2'd1;
                        state_s  = ST_SEL;
                    end else begin
                        state_s  = ST_EIP;
                    end
                end
                ST_EIP: begin
                    retire_s = 1'b1;
                    if (halt) begin
                        state_s = ST_HALTED;
                    end else if (cont_s) begin
                        state_s = ST_FETCH;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_HALTED: begin
                    state_s = ST_HALTED;
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end
    end

    // Sequencer state, decode latch, error pulse and retirement counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            op_idx_r  <= 2'd0;
            num_r     <= 4'd0;
            err_r     <= 1'b0;
            retired_r <= {CNT_W{1'b0}};
        end else begin
            state_r  <= state_s;
            op_idx_r <= op_idx_s;
            num_r    <= num_s;
            err_r    <= err_s;
            if (retire_s) begin
                retired_r <= retired_r + CNT_ONE;
            end else begin
                retired_r <= retired_r;
            end
        end
    end

    // Strobes fire on the cycle a state is left, so stall masks them directly
    assign ph_fetch    = (state_r == ST_FETCH)  & ~stall;
    assign ph_decode   = (state_r == ST_DECODE) & ~stall;
    assign ph_select   = (state_r == ST_SEL)    & ~stall;
    assign ph_exec     = (state_r == ST_EXEC)   & ~stall;
    assign ph_eip      = (state_r == ST_EIP)    & ~stall;
    assign op_idx      = op_idx_r;
    assign busy        = (state_r != ST_IDLE) && (state_r != ST_HALTED);
    assign halted      = (state_r == ST_HALTED);
    assign err_bad_ops = err_r;
    assign retired     = retired_r;

endmodule
